receiver: RTL and testbench

UART receive path, the counterpart of the existing transmitter on the same serial link. Accepts an asynchronous serial line (8N1, LSB first, idle high), synchronises it, locates each bit centre with a baud counter, and presents each received byte on a parallel bus with a one-cycle valid strobe. Frames with a bad stop bit are flagged and discarded. Sits between the board RX pin and the byte consumer; the transmitter and receiver share one configuration (baud_rate, clk_freq).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync.sv | 20 ++
 rtl/receiver.sv | 129 ++++++++++++
 tb/tb_receiver.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BITS  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous single-bit input; flops reset high (idle line level).
module uart_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= '1;
        else      ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/receiver.sv
// UART 8N1 receiver: synchronised rx, bit-centre sampling, byte out with valid / frame_err strobes.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | counting to the start-bit centre, rejecting glitches
// BITS  | sampling the eight data bits LSB first at bit centres
// STOP  | sampling the stop bit, then publishing the byte or flagging an error
module receiver
    import uart_pkg::*;
#(
    parameter int baud_rate = 9600,
    parameter int clk_freq  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic       rx_s;
    logic       rx_prev;
    logic [1:0] warm;

    uart_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           bit_idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [7:0]           data_n;
    logic                 valid_n, ferr_n;

    uart_sync #(.N(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // rx_prev only follows rx_s once the synchroniser holds real line samples,
    // so a line that is already low out of reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm    <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            warm    <= {warm[0], 1'b1};
            rx_prev <= warm[1] ? rx_s : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        shift_n = shift;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (rx_prev && !rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : BITS;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BITS: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    idx_n   = bit_idx + 3'd1;
                    if (bit_idx == IDX_LAST) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_receiver.sv
// Directed and randomised frames against an event-level model of the receiver's outputs.
module tb_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    typedef struct {
        bit          good;
        logic [7:0]  d;
        int unsigned cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          both_high = 0;
    logic [7:0]  last_good = 8'h00;
    ev_t         exp_q[$];
    ev_t         obs_q[$];

    receiver #(.baud_rate(10), .clk_freq(160)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid || frame_err) obs_q.push_back('{valid, data, cyc});
        if (valid && frame_err) both_high++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        exp_q.push_back('{stop, stop ? b : last_good, cyc + LAT});
        if (stop) last_good = b;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic expect_events(input string phase);
        check($sformatf("%s event_count", phase), 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s ev%0d kind", phase, i), 32'(obs_q[i].good), 32'(exp_q[i].good));
            check($sformatf("%s ev%0d data", phase, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
            check($sformatf("%s ev%0d cycle", phase, i), obs_q[i].cyc, exp_q[i].cyc);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        logic [7:0] partial;
        logic [7:0] rb;
        bit         rs;

        rst = 1'b0;
        rx  = 1'b1;
        tick(3);
        check("reset data", 32'(data), 32'h00);
        check("reset valid", 32'(valid), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        rst = 1'b1;
        tick(4 * CPB);

        send_frame(8'hA5, 1'b1);
        tick(2 * CPB);
        expect_events("a5");

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * CPB);
        expect_events("glitch");

        send_frame(8'h3C, 1'b0);
        tick(2 * CPB);
        expect_events("bad_stop");
        check("data held after frame_err", 32'(data), 32'hA5);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(2 * CPB);
        expect_events("back2back");

        partial = 8'hC3;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            tick(CPB);
        end
        rx = partial[3];
        tick(HALF);
        rst = 1'b0;
        #1;
        check("midframe reset data", 32'(data), 32'h00);
        check("midframe reset valid", 32'(valid), 32'h0);
        check("midframe reset frame_err", 32'(frame_err), 32'h0);
        last_good = 8'h00;
        rx = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(5 * CPB);
        expect_events("low_after_reset");
        rx = 1'b1;
        tick(2 * CPB);
        send_frame(8'h5A, 1'b1);
        tick(2 * CPB);
        expect_events("after_reset");

        exp_q.push_back('{1'b0, last_good, cyc + LAT});
        rx = 1'b0;
        tick(30 * CPB);
        rx = 1'b1;
        tick(CPB);
        expect_events("break");
        send_frame(8'h81, 1'b1);
        tick(2 * CPB);
        expect_events("after_break");

        for (int f = 0; f < 12; f++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs);
            if (rs) tick($urandom_range(0, 20));
            else    tick(CPB + $urandom_range(0, 10));
        end
        tick(2 * CPB);
        expect_events("random");

        check("valid and frame_err never together", 32'(both_high), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
